// File: rtl/noise_pkg.sv
// Shared definitions for the Rx noise generator and its statistics monitor.
// Sample width, the three expected sample values, FSM states and bin indices.
package noise_pkg;

    localparam int NOISE_W = 8;

    localparam logic signed [NOISE_W-1:0] NOISE_NEG  = -8'sd1;
    localparam logic signed [NOISE_W-1:0] NOISE_ZERO = 8'sd0;
    localparam logic signed [NOISE_W-1:0] NOISE_POS  = 8'sd1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        REPORT = 2'd2
    } noise_state_e;

    // Bit positions inside the one-hot bin select.
    localparam int BIN_NEG   = 0;
    localparam int BIN_ZERO  = 1;
    localparam int BIN_POS   = 2;
    localparam int BIN_OTHER = 3;

endpackage

// File: rtl/noise_bin_classify.sv
// Decodes one noise sample into a one-hot bin select (neg/zero/pos/other).
// Latency: combinational. Backpressure: none, pure decode.
module noise_bin_classify
    import noise_pkg::*;
(
    input  logic signed [NOISE_W-1:0] sample,
    output logic        [3:0]         bin_sel
);

    always_comb begin
        bin_sel = '0;
        if (sample == NOISE_NEG) begin
            bin_sel[BIN_NEG] = 1'b1;
        end else if (sample == NOISE_ZERO) begin
            bin_sel[BIN_ZERO] = 1'b1;
        end else if (sample == NOISE_POS) begin
            bin_sel[BIN_POS] = 1'b1;
        end else begin
            bin_sel[BIN_OTHER] = 1'b1;
        end
    end

endmodule

// File: rtl/noise_hist.sv
// Bins WINDOW accepted noise samples into -1/0/+1/other and sums them for DC bias.
// Latency: result_valid 1 clock after the WINDOW-th sample.
// Backpressure: result set held frozen in REPORT until result_ready; samples ignored.
module noise_hist
    import noise_pkg::*;
#(
    parameter int WINDOW = 1024,
    parameter int CNT_W  = $clog2(WINDOW + 1)
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      start,
    input  logic                      abort,
    input  logic signed [NOISE_W-1:0] noise_in,
    input  logic                      noise_in_valid,
    output logic                      busy,
    output logic        [CNT_W-1:0]   cnt_neg,
    output logic        [CNT_W-1:0]   cnt_zero,
    output logic        [CNT_W-1:0]   cnt_pos,
    output logic        [CNT_W-1:0]   cnt_other,
    output logic signed [CNT_W+7:0]   sum_out,
    output logic                      result_valid,
    input  logic                      result_ready
);

    localparam int                SUM_W    = CNT_W + NOISE_W;
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WINDOW - 1);

    noise_state_e     state, state_nxt;
    logic [CNT_W-1:0] cnt_samp;
    logic [3:0]       bin_sel;
    logic             clr;
    logic             acc_en;

    noise_bin_classify u_classify (
        .sample  (noise_in),
        .bin_sel (bin_sel)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        clr       = 1'b0;
        acc_en    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    clr       = 1'b1;
                    state_nxt = ACCUM;
                end
            end
            ACCUM: begin
                if (noise_in_valid) begin
                    acc_en = 1'b1;
                    if (cnt_samp == CNT_LAST) begin
                        state_nxt = REPORT;
                    end
                end
            end
            REPORT: begin
                if (result_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        // Abort overrides everything, including a start in IDLE.
        if (abort) begin
            state_nxt = IDLE;
            clr       = 1'b1;
            acc_en    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_neg   <= '0;
            cnt_zero  <= '0;
            cnt_pos   <= '0;
            cnt_other <= '0;
            cnt_samp  <= '0;
            sum_out   <= '0;
        end else if (clr) begin
            cnt_neg   <= '0;
            cnt_zero  <= '0;
            cnt_pos   <= '0;
            cnt_other <= '0;
            cnt_samp  <= '0;
            sum_out   <= '0;
        end else if (acc_en) begin
            if (bin_sel[BIN_NEG])   cnt_neg   <= cnt_neg + CNT_ONE;
            if (bin_sel[BIN_ZERO])  cnt_zero  <= cnt_zero + CNT_ONE;
            if (bin_sel[BIN_POS])   cnt_pos   <= cnt_pos + CNT_ONE;
            if (bin_sel[BIN_OTHER]) cnt_other <= cnt_other + CNT_ONE;
            cnt_samp <= cnt_samp + CNT_ONE;
            sum_out  <= sum_out + SUM_W'(noise_in);
        end
    end

    assign busy         = (state != IDLE);
    assign result_valid = (state == REPORT);

endmodule

// File: tb/tb_noise_hist.sv
// Directed bench for noise_hist at WINDOW=8, plus a WINDOW=1 instance for the single-sample case.
module tb_noise_hist;

    logic              clk = 1'b0;
    logic              rstn;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic signed [7:0] noise_in = 8'sd0;
    logic              noise_in_valid = 1'b0;
    logic              result_ready = 1'b0;
    logic              busy, result_valid;
    logic [3:0]        cnt_neg, cnt_zero, cnt_pos, cnt_other;
    logic signed [11:0] sum_out;

    logic              start1 = 1'b0;
    logic              valid1 = 1'b0;
    logic              ready1 = 1'b0;
    logic              busy1, rv1;
    logic [0:0]        neg1, zero1, pos1, oth1;
    logic signed [8:0] sum1;

    int vectors = 0;
    int errors  = 0;

    logic signed [7:0] seq_a [8] = '{8'sd0, 8'sd0, 8'sd0, 8'sd0, 8'sd1, 8'sd1, -8'sd1, -8'sd1};
    logic signed [7:0] seq_b [8] = '{8'sd5, -8'sd7, 8'sd1, 8'sd1, 8'sd1, 8'sd1, 8'sd1, 8'sd1};
    int                gaps  [8] = '{1, 0, 3, 2, 0, 1, 3, 2};
    logic signed [7:0] seq_c [5] = '{-8'sd1, 8'sd2, 8'sd0, 8'sd1, -8'sd1};

    always #5 clk = ~clk;

    noise_hist #(.WINDOW(8)) dut (
        .clk            (clk),
        .rstn           (rstn),
        .start          (start),
        .abort          (abort),
        .noise_in       (noise_in),
        .noise_in_valid (noise_in_valid),
        .busy           (busy),
        .cnt_neg        (cnt_neg),
        .cnt_zero       (cnt_zero),
        .cnt_pos        (cnt_pos),
        .cnt_other      (cnt_other),
        .sum_out        (sum_out),
        .result_valid   (result_valid),
        .result_ready   (result_ready)
    );

    noise_hist #(.WINDOW(1)) dut_w1 (
        .clk            (clk),
        .rstn           (rstn),
        .start          (start1),
        .abort          (abort),
        .noise_in       (noise_in),
        .noise_in_valid (valid1),
        .busy           (busy1),
        .cnt_neg        (neg1),
        .cnt_zero       (zero1),
        .cnt_pos        (pos1),
        .cnt_other      (oth1),
        .sum_out        (sum1),
        .result_valid   (rv1),
        .result_ready   (ready1)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic signed [7:0] v, input logic vl);
        noise_in       = v;
        noise_in_valid = vl;
        tick();
    endtask

    task automatic chk_all(input string tag, input int b, input int rv, input int n,
                           input int z, input int p, input int o, input int s);
        chk({tag, ".busy"}, int'(busy), b);
        chk({tag, ".result_valid"}, int'(result_valid), rv);
        chk({tag, ".cnt_neg"}, int'(cnt_neg), n);
        chk({tag, ".cnt_zero"}, int'(cnt_zero), z);
        chk({tag, ".cnt_pos"}, int'(cnt_pos), p);
        chk({tag, ".cnt_other"}, int'(cnt_other), o);
        chk({tag, ".sum_out"}, int'(sum_out), s);
    endtask

    initial begin
        rstn = 1'b0;
        #12;
        chk_all("reset", 0, 0, 0, 0, 0, 0, 0);
        chk("reset.w1_busy", int'(busy1), 0);
        tick();
        rstn = 1'b1;
        tick();

        // WINDOW=1: the first accepted sample goes straight to REPORT.
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        chk("w1.busy_after_start", int'(busy1), 1);
        noise_in = 8'sd1;
        valid1   = 1'b1;
        tick();
        valid1   = 1'b0;
        chk("w1.result_valid", int'(rv1), 1);
        chk("w1.cnt_pos", int'(pos1), 1);
        chk("w1.sum", int'(sum1), 1);
        ready1 = 1'b1;
        tick();
        ready1 = 1'b0;
        chk("w1.rv_drop", int'(rv1), 0);

        // Reset mid-ACCUM after three samples; the start-cycle sample is not counted.
        start = 1'b1;
        drive(8'sd1, 1'b1);
        start = 1'b0;
        chk_all("rst_pre.start", 1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) drive(8'sd1, 1'b1);
        chk_all("rst_pre.3smp", 1, 0, 0, 0, 3, 0, 3);
        noise_in_valid = 1'b0;
        #2;
        rstn = 1'b0;
        #1;
        chk_all("rst_mid", 0, 0, 0, 0, 0, 0, 0);
        tick();
        rstn = 1'b1;
        tick();

        // Fresh window with result_ready held high: REPORT lasts exactly one cycle.
        result_ready = 1'b1;
        start = 1'b1;
        drive(8'sd0, 1'b0);
        start = 1'b0;
        for (int i = 0; i < 7; i++) drive(seq_a[i], 1'b1);
        chk("a.rv_before_last", int'(result_valid), 0);
        drive(seq_a[7], 1'b1);
        noise_in_valid = 1'b0;
        chk_all("a.report", 1, 1, 2, 4, 2, 0, 0);
        tick();
        chk_all("a.idle_hold", 0, 0, 2, 4, 2, 0, 0);

        // Valid gaps are not counted; then backpressure with samples streaming.
        result_ready = 1'b0;
        start = 1'b1;
        drive(8'sd0, 1'b0);
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            for (int g = 0; g < gaps[i]; g++) drive(-8'sd1, 1'b0);
            drive(seq_b[i], 1'b1);
        end
        chk_all("b.report", 1, 1, 0, 0, 6, 2, 4);
        start = 1'b1;
        for (int i = 0; i < 10; i++) drive(8'sd1, 1'b1);
        start = 1'b0;
        noise_in_valid = 1'b0;
        chk_all("b.frozen", 1, 1, 0, 0, 6, 2, 4);
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
        chk_all("b.popped", 0, 0, 0, 0, 6, 2, 4);

        // start during ACCUM is ignored; abort after five samples clears everything.
        start = 1'b1;
        drive(8'sd3, 1'b1);
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            start = (i == 2);
            drive(seq_c[i], 1'b1);
        end
        start = 1'b0;
        chk_all("c.5smp", 1, 0, 2, 1, 1, 1, 1);
        abort = 1'b1;
        drive(8'sd1, 1'b1);
        abort = 1'b0;
        chk_all("c.abort", 0, 0, 0, 0, 0, 0, 0);

        // start and abort together in IDLE: abort wins.
        start = 1'b1;
        abort = 1'b1;
        drive(8'sd0, 1'b0);
        start = 1'b0;
        abort = 1'b0;
        chk("c.start_abort_busy", int'(busy), 0);
        tick();
        chk("c.start_abort_still_idle", int'(busy), 0);

        // Full window after abort counts exactly WINDOW samples.
        start = 1'b1;
        drive(8'sd0, 1'b0);
        start = 1'b0;
        for (int i = 0; i < 8; i++) drive(-8'sd1, 1'b1);
        noise_in_valid = 1'b0;
        chk_all("d.report", 1, 1, 8, 0, 0, 0, -8);
        result_ready = 1'b1;
        tick();
        chk("d.rv_drop", int'(result_valid), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/noise_hist.md
Name: noise_hist

Overview:
- Receive-side monitor for the Rx noise generator stream. Consumes signed 8-bit noise samples with a valid strobe.
- Over a programmable window of accepted samples it bins each sample as -1, 0, +1 or "other", and accumulates a signed running sum as a DC-bias check.
- Presents the result set through a valid/ready handshake.
- Sits in the Rx noise simulation bench to check the generator's 50/25/25 distribution, and later sits on-chip for in-FPGA statistics.

Parameters:
- WINDOW, 1024, number of accepted samples per measurement (>= 1).
- CNT_W, $clog2(WINDOW+1), width of every bin counter and of the sample counter.

Ports:
- clk  input  1  system clock.
- rstn  input  1  asynchronous active-low reset.
- start  input  1  single-cycle pulse; begins a measurement when idle.
- abort  input  1  synchronous abort; returns to IDLE and discards partial counts.
- noise_in  input  8  signed noise sample.
- noise_in_valid  input  1  noise_in is valid this cycle.
- busy  output  1  high in ACCUM and REPORT.
- cnt_neg  output  CNT_W  count of samples equal to -1.
- cnt_zero  output  CNT_W  count of samples equal to 0.
- cnt_pos  output  CNT_W  count of samples equal to +1.
- cnt_other  output  CNT_W  count of all other sample values.
- sum_out  output  CNT_W+8 signed  running sum of all accepted samples.
- result_valid  output  1  result set is stable and valid.
- result_ready  input  1  consumer accepts the result.

Behaviour:
- Reset (rstn low, asynchronous): state IDLE; busy=0; result_valid=0; all counters, sample count and sum_out = 0.
- States: IDLE, ACCUM, REPORT.
- IDLE:
  - noise_in_valid is ignored.
  - On start=1, clear all counters and the sum, then enter ACCUM on the next edge.
  - The sample on the start cycle is not counted.
  - Outputs keep the last result until start clears them.
- ACCUM:
  - Each cycle with noise_in_valid=1, increment exactly one bin by 1, add sign-extended noise_in to sum_out, and increment the sample count.
  - When the WINDOW-th sample is accepted, register it and enter REPORT on that same edge. result_valid is 1 in the following cycle, so latency from the last sample to result_valid is 1 clock.
  - start is ignored while in ACCUM.
- REPORT:
  - result_valid=1. All count and sum outputs are frozen; noise_in_valid is ignored.
  - When result_valid and result_ready are both 1, go to IDLE on that edge. result_valid is 0 in the next cycle.
  - result_ready may be held high continuously, in which case REPORT lasts exactly 1 cycle.
  - start is ignored while in REPORT.
- Invariant: at REPORT, cnt_neg + cnt_zero + cnt_pos + cnt_other == WINDOW.
- Counters cannot overflow because they are bounded by WINDOW. sum_out range is +/-128*WINDOW and fits CNT_W+8 signed.
- abort:
  - Has priority over every other input in any state.
  - Next state is IDLE; result_valid=0; busy=0.
  - Counters are cleared to 0.
- Simultaneous start and abort in IDLE: abort wins and the block stays IDLE.
- rstn asserted mid-ACCUM or mid-REPORT: immediate return to reset values; no partial result is presented.
- WINDOW=1: the first accepted sample moves the block straight to REPORT.

Decomposition:
- Shared package noise_pkg:
  - State enum typedef (IDLE/ACCUM/REPORT).
  - Sample-value constants NOISE_NEG=-1, NOISE_ZERO=0, NOISE_POS=1.
  - Sample width constant NOISE_W=8. This package is shared with the noise generator.
- Sub-module noise_bin_classify: combinational decode of noise_in into a one-hot 4-bit bin select (neg/zero/pos/other). It is instantiated once; the counters and the FSM stay in noise_hist.

Test Plan (WINDOW=8):
- Reset mid-ACCUM after 3 samples -> all outputs 0, busy=0, result_valid=0 immediately; a following start plus 8 samples gives a full fresh result.
- start, then samples 0,0,0,0,1,1,-1,-1 each valid, result_ready=1 -> result_valid one cycle after the 8th sample for exactly 1 cycle; cnt_zero=4, cnt_pos=2, cnt_neg=2, cnt_other=0, sum_out=0.
- start, samples 5,-7,1,1,1,1,1,1 with valid gaps of 0-3 idle cycles -> cnt_other=2, cnt_pos=6, sum_out=4; gaps are not counted.
- Backpressure: result_ready=0 for 10 cycles after REPORT entry, with noise_in_valid=1 streaming -> outputs frozen, result_valid stays 1; ready pulse -> IDLE next cycle.
- abort asserted after 5 samples -> IDLE next cycle with counters cleared; start asserted during ACCUM and REPORT has no effect, and the sample on the start cycle is not counted.
- Closed loop with the noise generator, WINDOW=1024 -> bin sum equals 1024, cnt_other=0, and cnt_zero lies within 512 +/- 64.
